// File: rtl/sha_seq_pkg.sv
// Shared constants, state encoding and message-schedule helpers for the SHA-256 round sequencer.
package sha_seq_pkg;

  localparam int unsigned NumWords = 16;

  // SHA-256 round constants K[0..63].
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Initial hash value, H0 in [31:0].
  localparam logic [255:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StArm,
    StRound,
    StAcc
  } state_e;

  // sigma0 = ROTR7 ^ ROTR18 ^ SHR3
  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  // sigma1 = ROTR17 ^ ROTR19 ^ SHR10
  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha_round_sequencer_if.sv
// Host word stream, control/status and round-unit bus of the SHA-256 round sequencer.
interface sha_round_sequencer_if #(
  parameter int unsigned DELAY_W = 7
) ();

  logic                start;
  logic                init_hash;
  logic                busy;
  logic                done;
  logic                msg_valid;
  logic                msg_ready;
  logic [31:0]         msg_data;
  logic                ru_run;
  logic                ru_running;
  logic [DELAY_W-1:0]  ru_delay;
  logic [255:0]        ru_h;
  logic [31:0]         ru_w;
  logic [31:0]         ru_k;
  logic [255:0]        ru_out;
  logic [255:0]        digest;

  // Host plus round unit side.
  modport master (
    output start, init_hash, msg_valid, msg_data, ru_out,
    input  busy, done, msg_ready, ru_run, ru_running, ru_delay, ru_h, ru_w, ru_k, digest
  );

  // Sequencer side.
  modport slave (
    input  start, init_hash, msg_valid, msg_data, ru_out,
    output busy, done, msg_ready, ru_run, ru_running, ru_delay, ru_h, ru_w, ru_k, digest
  );

endinterface

// File: rtl/sha_msg_schedule.sv
// 16-word circular message buffer: loaded word by word, then expands W[16..63] in place,
// one word per round.
module sha_msg_schedule
  import sha_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic [3:0]  load_idx,
  input  logic [31:0] load_data,
  input  logic        round_en,
  input  logic [5:0]  round_idx,
  output logic [31:0] w
);

  logic [31:0] mem_q [NumWords];
  logic [3:0]  idx_2, idx_7, idx_15, idx_16;
  logic [31:0] w_exp;
  logic        expand;

  // Circular offsets: slot (t-16)%16 is the slot W_t overwrites.
  assign idx_2  = round_idx[3:0] - 4'd2;
  assign idx_7  = round_idx[3:0] - 4'd7;
  assign idx_15 = round_idx[3:0] - 4'd15;
  assign idx_16 = round_idx[3:0];

  assign expand = (round_idx[5:4] != 2'b00);
  assign w_exp  = sigma1(mem_q[idx_2]) + mem_q[idx_7] + sigma0(mem_q[idx_15]) + mem_q[idx_16];
  assign w      = expand ? w_exp : mem_q[idx_16];

  // Buffer write: host load, or in-place store of the expanded word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NumWords; i++) begin
        mem_q[i] <= '0;
      end
    end else if (load_en) begin
      mem_q[load_idx] <= load_data;
    end else if (round_en && expand) begin
      mem_q[idx_16] <= w_exp;
    end
  end

endmodule

// File: rtl/sha_round_sequencer.sv
// Runs one SHA-256 compression on an external 8-word round unit: loads a 16-word block,
// feeds W_t/K_t for 64 rounds, then folds the unit result into the hash state.
// Build option: SHA_SEQ_CHAIN_EN honours init_hash so H chains across blocks; without it
// every accepted start reloads the IV.
module sha_round_sequencer
  import sha_seq_pkg::*;
#(
  parameter int unsigned DELAY_W = 7,
  parameter int unsigned ROUNDS  = 64
) (
  input logic                  clk,
  input logic                  rst,
  sha_round_sequencer_if.slave bus
);

  localparam logic [5:0]         LastRound = 6'(ROUNDS - 1);
  localparam logic [DELAY_W-1:0] DelayZero = '0;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q;
  logic [5:0]    t_q;
  logic [255:0]  h_q;
  logic [255:0]  h_sum;
  logic          done_q;
  logic          load_iv;
  logic          word_acc;
  logic [31:0]   sched_w;
  logic          busy_c, ready_c, run_c, running_c;

`ifdef SHA_SEQ_CHAIN_EN
  assign load_iv = bus.init_hash;
`else
  logic unused_init_hash;
  assign unused_init_hash = bus.init_hash;
  assign load_iv          = 1'b1;
`endif

  assign word_acc = ready_c && bus.msg_valid;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and decoded control outputs.
  always_comb begin
    state_d   = state_q;
    busy_c    = 1'b1;
    ready_c   = 1'b0;
    run_c     = 1'b0;
    running_c = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy_c = 1'b0;
        if (bus.start) state_d = StLoad;
      end
      StLoad: begin
        ready_c = 1'b1;
        if (bus.msg_valid && cnt_q == 4'd15) state_d = StArm;
      end
      StArm: begin
        run_c   = 1'b1;
        state_d = StRound;
      end
      StRound: begin
        running_c = 1'b1;
        if (t_q == LastRound) state_d = StAcc;
      end
      StAcc: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Final feed-forward adder: H_i + out_i, word-wise mod 2^32.
  always_comb begin
    h_sum = '0;
    for (int i = 0; i < 8; i++) begin
      h_sum[32*i +: 32] = h_q[32*i +: 32] + bus.ru_out[32*i +: 32];
    end
  end

  // Word counter, round index, hash state and done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      t_q    <= '0;
      h_q    <= IV;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == StAcc);
      if (state_q == StIdle) begin
        cnt_q <= '0;
        if (bus.start && load_iv) h_q <= IV;
      end
      if (word_acc) cnt_q <= cnt_q + 4'd1;
      if (state_q == StArm) t_q <= '0;
      if (state_q == StRound) t_q <= t_q + 6'd1;
      if (state_q == StAcc) h_q <= h_sum;
    end
  end

  sha_msg_schedule u_sched (
    .clk       (clk),
    .rst       (rst),
    .load_en   (word_acc),
    .load_idx  (cnt_q),
    .load_data (bus.msg_data),
    .round_en  (running_c),
    .round_idx (t_q),
    .w         (sched_w)
  );

  assign bus.busy       = busy_c;
  assign bus.done       = done_q;
  assign bus.msg_ready  = ready_c;
  assign bus.ru_run     = run_c;
  assign bus.ru_running = running_c;
  assign bus.ru_delay   = DelayZero;
  // W/K are forced to zero outside ROUND so the unit sees quiet inputs when idle.
  assign bus.ru_w       = running_c ? sched_w : 32'h0;
  assign bus.ru_k       = running_c ? K[t_q] : 32'h0;
  assign bus.ru_h       = h_q;
  assign bus.digest     = h_q;

endmodule

// File: doc/sha_round_sequencer.md
# sha_round_sequencer

Controller that runs one SHA-256 compression on the 8-word round unit. It accepts a 16-word message block over a valid/ready stream and expands the message schedule W[16..63]. It supplies W_t and K_t one round per cycle, drives the unit's run/running/delay controls, then adds the unit's final a..h into the hash state to produce the 256-bit digest. It sits between the host/DMA word stream and the round datapath; one sequencer owns one round unit.

## Interface
- DELAY_W, 7, width of round-unit delay field
- ROUNDS, 64, round count (fixed by SHA-256; not for tuning)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- start  in  1  begin compression of next block; sampled only in IDLE
- init_hash  in  1  sampled with start: 1 = load IV into H, 0 = chain from current H
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, digest updated
- msg_valid  in  1  message word valid
- msg_ready  out  1  high only in LOAD
- msg_data  in  32  message word, big-endian word order W0 first
- ru_run  out  1  to round unit run
- ru_running  out  1  to round unit running
- ru_delay  out  DELAY_W  to round unit delay0, constant 0
- ru_h  out  256  H0..H7 to unit in0..in7, H0 in [31:0]
- ru_w  out  32  to unit in8
- ru_k  out  32  to unit in9
- ru_out  in  256  unit out0..out7, out0 in [31:0]
- digest  out  256  H register, H0 in [31:0]

## Operation
- States: IDLE, LOAD, ARM, ROUND, ACC.
- IDLE: start=1 -> LOAD. With init_hash=1, H <= IV in the same edge. Word counter is cleared.
- LOAD: msg_ready=1. Each msg_valid&msg_ready writes buffer[cnt] and increments cnt. The 16th handshake -> ARM.
- ARM (1 cycle): ru_run=1, ru_running=0. t is cleared.
- ROUND (64 cycles, t=0..63): ru_running=1, ru_k=K[t].
  - t<16: ru_w = buffer[t].
  - t>=16: ru_w = σ1(buf[(t-2)%16]) + buf[(t-7)%16] + σ0(buf[(t-15)%16]) + buf[(t-16)%16] mod 2^32, and the value is written to buf[t%16] at the edge.
  - σ0 = ROTR7^ROTR18^SHR3; σ1 = ROTR17^ROTR19^SHR10.
  - t=63 -> ACC.
- ACC (1 cycle): ru_running=0. H_i <= H_i + ru_out_i mod 2^32 for i=0..7. done is registered high for the following cycle. -> IDLE.
- ru_h = H at all times; the unit consumes it only at t=0.
- start while busy: ignored, not queued.
- msg_valid outside LOAD: ignored, no data consumed.
- Reset (any state, including mid-ROUND): state=IDLE, cnt=t=0, buffer=0, H=IV, all control outputs 0. No partial digest is produced.
- Reset values: busy=0, done=0, msg_ready=0, ru_run=0, ru_running=0, ru_delay=0, ru_w=0, ru_k=0, ru_h=digest=IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19).

## Timing
- Edge E = the 16th accepted word. ARM is cycle E+1; ROUND t=0 is E+2; t=63 is E+65; ACC is E+66; done=1 and new digest visible at E+67.
- With msg_valid held high, start-to-done is 1 (IDLE edge) + 16 + 1 + 64 + 1 + 1 = 84 cycles; back-to-back start is accepted the cycle done is high.
- Round-unit contract: one run pulse with delay0=0. The first running cycle loads in0..in7 and executes round 0. Each later running cycle executes one round. out0..out7 hold round-63 results while running=0.
- Stalls on msg_valid=0 only extend LOAD; ROUND is never stalled.

## Configuration
- SHA_SEQ_CHAIN_EN defined: init_hash is honoured; H persists across blocks for multi-block messages.
- Undefined: init_hash is ignored, H is loaded with IV on every accepted start (single-block only). The digest register still holds the last result until the next start.

## Structure
- Package sha_seq_pkg: K[0..63] constant array, IV constant, state enum, σ0/σ1 functions.
- Sub-module sha_msg_schedule: 16x32 circular buffer, load port, round index input, W_t output and in-place write for t>=16.
- Sequencer top holds the FSM, counters, H register and the final adder.

## Test plan
- "abc" padded block (61626380, 0x00…, 00000018), init_hash=1 -> digest H0..H7 = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; done exactly E+67.
- Empty-message block (80000000, zeros) -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": block1 init_hash=1, block2 init_hash=0 (CHAIN_EN) -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Random msg_valid gaps during LOAD -> identical digest as no-gap run; ROUND still 64 contiguous ru_running cycles.
- start pulses during LOAD/ROUND plus msg_valid=1 in IDLE -> ignored; no extra done; msg_ready stays 0 outside LOAD.
- rst low at t=30 -> all outputs at reset values immediately; digest=IV; next "abc" run gives the correct digest.
